// File: rtl/fbuf_pkg.sv
// Shared framebuffer defaults and the write-arbiter state encoding.
package fbuf_pkg;

   localparam int FBUF_ADDR_WIDTH_DEF = 19;
   localparam int FBUF_DATA_WIDTH_DEF = 8;
   localparam int FBUF_DEPTH_DEF      = 307200;
   localparam logic [7:0] FBUF_CLEAR_COLOR_DEF = 8'h00;

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_CLEAR = 1'b1
   } fbuf_state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin grant; the priority pointer moves only on a transfer.
module rr_arbiter_2 (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   logic prio1_q;
   logic prio1_d;

   // Grants are only ever raised on a valid request, so a grant is a transfer.
   always_comb begin
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      prio1_d = prio1_q;
      if (en) begin
         if (req0 && (!req1 || !prio1_q)) begin
            gnt0 = 1'b1;
         end else if (req1) begin
            gnt1 = 1'b1;
         end
      end
      if (gnt0) begin
         prio1_d = 1'b1;
      end else if (gnt1) begin
         prio1_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio1_q <= 1'b0;
      end else begin
         prio1_q <= prio1_d;
      end
   end

endmodule

// File: rtl/fbuf_write_arbiter.sv
// Framebuffer write-port owner: arbitrates two pixel requesters and runs the
// full-buffer clear sequence through one registered write port.
module fbuf_write_arbiter
   import fbuf_pkg::*;
#(
   parameter int FBUF_ADDR_WIDTH = FBUF_ADDR_WIDTH_DEF,
   parameter int FBUF_DATA_WIDTH = FBUF_DATA_WIDTH_DEF,
   parameter int FBUF_DEPTH      = FBUF_DEPTH_DEF,
   parameter logic [FBUF_DATA_WIDTH-1:0] CLEAR_COLOR = FBUF_DATA_WIDTH'(FBUF_CLEAR_COLOR_DEF)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req0_valid,
   input  logic [FBUF_ADDR_WIDTH-1:0] req0_address,
   input  logic [FBUF_DATA_WIDTH-1:0] req0_color,
   output logic                       req0_ready,
   input  logic                       req1_valid,
   input  logic [FBUF_ADDR_WIDTH-1:0] req1_address,
   input  logic [FBUF_DATA_WIDTH-1:0] req1_color,
   output logic                       req1_ready,
   input  logic                       clear_start,
   output logic                       clear_busy,
   output logic                       clear_done,
   output logic [FBUF_ADDR_WIDTH-1:0] pixel_fbuf_address,
   output logic [FBUF_DATA_WIDTH-1:0] pixel_fbuf_color,
   output logic                       pixel_fbuf_wr_en
);

   if (FBUF_DEPTH == 0 || longint'(FBUF_DEPTH) > (64'd1 << FBUF_ADDR_WIDTH)) begin : g_bad_depth
      $error("fbuf_write_arbiter: FBUF_DEPTH must be in 1..2**FBUF_ADDR_WIDTH");
   end

   localparam logic [FBUF_ADDR_WIDTH-1:0] LAST_ADDR = FBUF_ADDR_WIDTH'(FBUF_DEPTH - 1);

   fbuf_state_e state_q, state_d;
   logic [FBUF_ADDR_WIDTH-1:0] count_q, count_d;
   logic [FBUF_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [FBUF_DATA_WIDTH-1:0] color_q, color_d;
   logic wrEn_q, wrEn_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic grantEn;
   logic gnt0;
   logic gnt1;

   // rst_n gates the grants so no ready can leak out while reset is held.
   assign grantEn = rst_n && (state_q == ST_ARB) && !clear_start;

   rr_arbiter_2 u_rr (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (grantEn),
      .req0 (req0_valid),
      .req1 (req1_valid),
      .gnt0 (gnt0),
      .gnt1 (gnt1)
   );

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      addr_d  = addr_q;
      color_d = color_q;
      wrEn_d  = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         ST_ARB: begin
            if (clear_start) begin
               state_d = ST_CLEAR;
               count_d = '0;
            end else if (gnt0) begin
               wrEn_d  = 1'b1;
               addr_d  = req0_address;
               color_d = req0_color;
            end else if (gnt1) begin
               wrEn_d  = 1'b1;
               addr_d  = req1_address;
               color_d = req1_color;
            end
         end
         ST_CLEAR: begin
            wrEn_d  = 1'b1;
            addr_d  = count_q;
            color_d = CLEAR_COLOR;
            count_d = count_q + 1'b1;
            if (count_q == LAST_ADDR) begin
               state_d = ST_ARB;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_ARB;
      endcase
      busy_d = (state_d == ST_CLEAR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ARB;
         count_q <= '0;
         addr_q  <= '0;
         color_q <= '0;
         wrEn_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         color_q <= color_d;
         wrEn_q  <= wrEn_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign pixel_fbuf_address = addr_q;
   assign pixel_fbuf_color   = color_q;
   assign pixel_fbuf_wr_en   = wrEn_q;
   assign clear_busy         = busy_q;
   assign clear_done         = done_q;

endmodule

// File: tb/tb_fbuf_write_arbiter.sv
// Randomized scoreboard bench for fbuf_write_arbiter with a 16-word buffer.
module tb_fbuf_write_arbiter;

   localparam int AW = 5;
   localparam int DW = 8;
   localparam int DEPTH = 16;
   localparam logic [DW-1:0] CLR = 8'h00;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req0_valid = 1'b0, req1_valid = 1'b0, clear_start = 1'b0;
   logic [AW-1:0] req0_address = '0, req1_address = '0;
   logic [DW-1:0] req0_color = '0, req1_color = '0;
   logic req0_ready, req1_ready, clear_busy, clear_done, pixel_fbuf_wr_en;
   logic [AW-1:0] pixel_fbuf_address;
   logic [DW-1:0] pixel_fbuf_color;

   fbuf_write_arbiter #(
      .FBUF_ADDR_WIDTH(AW),
      .FBUF_DATA_WIDTH(DW),
      .FBUF_DEPTH     (DEPTH),
      .CLEAR_COLOR    (CLR)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .req0_valid        (req0_valid),
      .req0_address      (req0_address),
      .req0_color        (req0_color),
      .req0_ready        (req0_ready),
      .req1_valid        (req1_valid),
      .req1_address      (req1_address),
      .req1_color        (req1_color),
      .req1_ready        (req1_ready),
      .clear_start       (clear_start),
      .clear_busy        (clear_busy),
      .clear_done        (clear_done),
      .pixel_fbuf_address(pixel_fbuf_address),
      .pixel_fbuf_color  (pixel_fbuf_color),
      .pixel_fbuf_wr_en  (pixel_fbuf_wr_en)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] color;
      logic          busy;
      logic          done;
   } outExp_t;

   typedef struct {
      logic r0;
      logic r1;
   } rdyExp_t;

   outExp_t outQ[$];
   rdyExp_t rdyQ[$];
   int errors = 0;
   int checks = 0;

   // Reference model: "is a clear running, which word is next, who waits longest".
   bit mClearing = 1'b0;
   int mNext = 0;
   bit mPrefer1 = 1'b0;
   logic [AW-1:0] mAddr = '0;
   logic [DW-1:0] mColor = '0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] c0,
                                input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] c1,
                                input logic cs);
      rdyExp_t r;
      outExp_t o;
      int w;
      @(negedge clk);
      req0_valid = v0; req0_address = a0; req0_color = c0;
      req1_valid = v1; req1_address = a1; req1_color = c1;
      clear_start = cs;
      r.r0 = 1'b0; r.r1 = 1'b0;
      o.wr = 1'b0; o.done = 1'b0;
      w = -1;
      if (!mClearing) begin
         if (cs) begin
            mClearing = 1'b1;
            mNext = 0;
         end else begin
            if (v0 && v1) w = mPrefer1 ? 1 : 0;
            else if (v0) w = 0;
            else if (v1) w = 1;
            if (w == 0) begin
               r.r0 = 1'b1; o.wr = 1'b1; mAddr = a0; mColor = c0; mPrefer1 = 1'b1;
            end else if (w == 1) begin
               r.r1 = 1'b1; o.wr = 1'b1; mAddr = a1; mColor = c1; mPrefer1 = 1'b0;
            end
         end
      end else begin
         o.wr = 1'b1;
         mAddr = AW'(mNext);
         mColor = CLR;
         o.done = (mNext == DEPTH - 1);
         mNext++;
         if (mNext == DEPTH) mClearing = 1'b0;
      end
      o.addr = mAddr;
      o.color = mColor;
      o.busy = mClearing;
      rdyQ.push_back(r);
      outQ.push_back(o);
   endtask

   task automatic doReset();
      @(negedge clk);
      outQ.delete();
      rdyQ.delete();
      req0_valid = 1'b1; req1_valid = 1'b1; clear_start = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      checkOutput("rst_wr_en", 32'(pixel_fbuf_wr_en), 0);
      checkOutput("rst_address", 32'(pixel_fbuf_address), 0);
      checkOutput("rst_color", 32'(pixel_fbuf_color), 0);
      checkOutput("rst_busy", 32'(clear_busy), 0);
      checkOutput("rst_done", 32'(clear_done), 0);
      checkOutput("rst_req0_ready", 32'(req0_ready), 0);
      checkOutput("rst_req1_ready", 32'(req1_ready), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      mClearing = 1'b0; mNext = 0; mPrefer1 = 1'b0; mAddr = '0; mColor = '0;
   endtask

   // Ready monitor: combinational grants sampled mid-low-phase.
   initial begin
      rdyExp_t r;
      forever begin
         @(negedge clk);
         #2;
         if (rdyQ.size() > 0) begin
            r = rdyQ.pop_front();
            checkOutput("req0_ready", 32'(req0_ready), 32'(r.r0));
            checkOutput("req1_ready", 32'(req1_ready), 32'(r.r1));
            checkOutput("ready_onehot", 32'(req0_ready & req1_ready), 0);
         end
      end
   end

   // Write-port monitor: registered outputs sampled just after the edge.
   initial begin
      outExp_t o;
      forever begin
         @(posedge clk);
         #1;
         if (outQ.size() > 0) begin
            o = outQ.pop_front();
            checkOutput("wr_en", 32'(pixel_fbuf_wr_en), 32'(o.wr));
            checkOutput("address", 32'(pixel_fbuf_address), 32'(o.addr));
            checkOutput("color", 32'(pixel_fbuf_color), 32'(o.color));
            checkOutput("clear_busy", 32'(clear_busy), 32'(o.busy));
            checkOutput("clear_done", 32'(clear_done), 32'(o.done));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      doReset();

      // Single requester, fixed pixel.
      applyStimulus(1'b1, 5'd3, 8'hE0, 1'b0, 5'd0, 8'h00, 1'b0);
      applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0);

      // Contention straight after reset alternates starting with req0.
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, AW'($urandom), DW'($urandom), 1'b1, AW'($urandom), DW'($urandom), 1'b0);
      end

      // Clear wins over req1, a second clear_start mid-sequence is ignored,
      // then req1 is served right after the last clear word.
      applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd9, 8'h5A, 1'b1);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd9, 8'h5A, (i == 5));
      end
      applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd9, 8'h5A, 1'b0);
      applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0);

      // Reset lands in the middle of a clear.
      applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b1);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0);
      end
      doReset();
      applyStimulus(1'b1, 5'd1, 8'h11, 1'b1, 5'd2, 8'h22, 1'b0);
      applyStimulus(1'b1, 5'd1, 8'h11, 1'b1, 5'd2, 8'h22, 1'b0);

      // Random traffic with occasional clears.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(1'($urandom), AW'($urandom), DW'($urandom),
                       1'($urandom), AW'($urandom), DW'($urandom),
                       ($urandom_range(0, 39) == 0));
      end
      applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0);
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
